// File: rtl/crtc_modeset_pkg.sv
// Shared CRTC register map, field layout and built-in video mode table.
package crtc_modeset_pkg;

    // CRTC register byte offsets
    localparam logic [31:0] CRTC_REG_CONTROL = 32'h00;
    localparam logic [31:0] CRTC_REG_HACTIVE = 32'h04;
    localparam logic [31:0] CRTC_REG_HFW     = 32'h08;
    localparam logic [31:0] CRTC_REG_HSW     = 32'h0C;
    localparam logic [31:0] CRTC_REG_HBW     = 32'h10;
    localparam logic [31:0] CRTC_REG_VACTIVE = 32'h14;
    localparam logic [31:0] CRTC_REG_VFW     = 32'h18;
    localparam logic [31:0] CRTC_REG_VSW     = 32'h1C;
    localparam logic [31:0] CRTC_REG_VBW     = 32'h20;

    // Timing value field position and CONTROL bit positions
    localparam int unsigned CRTC_FIELD_LSB   = 0;
    localparam int unsigned CRTC_CTRL_ENABLE = 0;
    localparam int unsigned CRTC_CTRL_HSPN   = 1;
    localparam int unsigned CRTC_CTRL_VSPN   = 2;

    localparam logic [3:0] CRTC_LAST_INDEX = 4'd9;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;

    typedef struct packed {
        logic [11:0] h_active;
        logic [11:0] h_fw;
        logic [11:0] h_sw;
        logic [11:0] h_bw;
        logic        h_pn;
        logic [11:0] v_active;
        logic [11:0] v_fw;
        logic [11:0] v_sw;
        logic [11:0] v_bw;
        logic        v_pn;
    } mode_t;

    localparam mode_t CRTC_MODE_0 = '{h_active: 12'd1920, h_fw: 12'd88, h_sw: 12'd44,
                                      h_bw: 12'd148, h_pn: 1'b0, v_active: 12'd1080,
                                      v_fw: 12'd4, v_sw: 12'd5, v_bw: 12'd36, v_pn: 1'b0};
    localparam mode_t CRTC_MODE_1 = '{h_active: 12'd1680, h_fw: 12'd104, h_sw: 12'd176,
                                      h_bw: 12'd280, h_pn: 1'b1, v_active: 12'd1050,
                                      v_fw: 12'd3, v_sw: 12'd6, v_bw: 12'd30, v_pn: 1'b0};
    localparam mode_t CRTC_MODE_2 = '{h_active: 12'd1280, h_fw: 12'd110, h_sw: 12'd40,
                                      h_bw: 12'd220, h_pn: 1'b0, v_active: 12'd720,
                                      v_fw: 12'd5, v_sw: 12'd5, v_bw: 12'd20, v_pn: 1'b0};
    localparam mode_t CRTC_MODE_3 = '{h_active: 12'd640, h_fw: 12'd16, h_sw: 12'd96,
                                      h_bw: 12'd48, h_pn: 1'b1, v_active: 12'd480,
                                      v_fw: 12'd10, v_sw: 12'd2, v_bw: 12'd33, v_pn: 1'b1};

    function automatic mode_t crtc_mode_lookup(input logic [1:0] mode);
        case (mode)
            2'd0:    return CRTC_MODE_0;
            2'd1:    return CRTC_MODE_1;
            2'd2:    return CRTC_MODE_2;
            default: return CRTC_MODE_3;
        endcase
    endfunction

    // Zero-extended 12-bit timing value placed at its field position
    function automatic logic [31:0] crtc_field(input logic [11:0] value);
        return 32'(value) << CRTC_FIELD_LSB;
    endfunction

    function automatic logic [31:0] crtc_control(input logic enable, input logic hspn,
                                                 input logic vspn);
        logic [31:0] ctrl;
        ctrl                   = '0;
        ctrl[CRTC_CTRL_ENABLE] = enable;
        ctrl[CRTC_CTRL_HSPN]   = hspn;
        ctrl[CRTC_CTRL_VSPN]   = vspn;
        return ctrl;
    endfunction

endpackage

// File: rtl/crtc_mode_rom.sv
// Combinational table: (mode, write index) -> register offset and write data.
module crtc_mode_rom
    import crtc_modeset_pkg::*;
(
    input  logic [1:0]  mode_i,
    input  logic [3:0]  index_i,
    output logic [31:0] offset_o,
    output logic [31:0] data_o
);

    mode_t mode;
    assign mode = crtc_mode_lookup(mode_i);

    // Disable, vertical timings, horizontal timings, re-enable
    always_comb begin
        offset_o = '0;
        data_o   = '0;
        case (index_i)
            4'd0: begin
                offset_o = CRTC_REG_CONTROL;
                data_o   = crtc_control(1'b0, mode.h_pn, mode.v_pn);
            end
            4'd1: begin offset_o = CRTC_REG_VACTIVE; data_o = crtc_field(mode.v_active); end
            4'd2: begin offset_o = CRTC_REG_VFW;     data_o = crtc_field(mode.v_fw);     end
            4'd3: begin offset_o = CRTC_REG_VSW;     data_o = crtc_field(mode.v_sw);     end
            4'd4: begin offset_o = CRTC_REG_VBW;     data_o = crtc_field(mode.v_bw);     end
            4'd5: begin offset_o = CRTC_REG_HACTIVE; data_o = crtc_field(mode.h_active); end
            4'd6: begin offset_o = CRTC_REG_HFW;     data_o = crtc_field(mode.h_fw);     end
            4'd7: begin offset_o = CRTC_REG_HSW;     data_o = crtc_field(mode.h_sw);     end
            4'd8: begin offset_o = CRTC_REG_HBW;     data_o = crtc_field(mode.h_bw);     end
            4'd9: begin
                offset_o = CRTC_REG_CONTROL;
                data_o   = crtc_control(1'b1, mode.h_pn, mode.v_pn);
            end
            default: begin
                offset_o = '0;
                data_o   = '0;
            end
        endcase
    end

endmodule

// File: rtl/crtc_modeset.sv
// Mode-set sequencer: AXI-Lite write-only master issuing the ten-write CRTC sequence.
module crtc_modeset
    import crtc_modeset_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  mode_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        cfg_awvalid_o,
    output logic [31:0] cfg_awaddr_o,
    input  logic        cfg_awready_i,
    output logic        cfg_wvalid_o,
    output logic [31:0] cfg_wdata_o,
    output logic [3:0]  cfg_wstrb_o,
    input  logic        cfg_wready_i,
    input  logic        cfg_bvalid_i,
    input  logic [1:0]  cfg_bresp_i,
    output logic        cfg_bready_o
);

    typedef enum logic [1:0] {StIdle, StWr, StResp, StDone} state_e;

    state_e      state_q;
    logic [1:0]  mode_q;
    logic [3:0]  idx_q;
    logic        aw_done_q, w_done_q;
    logic        awvalid_q, wvalid_q, bready_q;
    logic [31:0] awaddr_q, wdata_q;
    logic        busy_q, done_q, error_q;

    logic [1:0]  rom_mode;
    logic [3:0]  rom_idx;
    logic [31:0] rom_offset, rom_data;
    logic        aw_hs, w_hs;

    // ROM looks up the write about to be issued, so address/data load on entry to WR
    always_comb begin
        rom_mode = mode_q;
        rom_idx  = idx_q + 4'd1;
        if (state_q == StIdle) begin
            rom_mode = mode_i;
            rom_idx  = 4'd0;
        end
    end

    crtc_mode_rom u_rom (
        .mode_i   (rom_mode),
        .index_i  (rom_idx),
        .offset_o (rom_offset),
        .data_o   (rom_data)
    );

    assign aw_hs = awvalid_q & cfg_awready_i;
    assign w_hs  = wvalid_q & cfg_wready_i;

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            mode_q    <= 2'd0;
            idx_q     <= 4'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        mode_q    <= mode_i;
                        error_q   <= 1'b0;
                        idx_q     <= 4'd0;
                        busy_q    <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        awaddr_q  <= BASE_ADDR + rom_offset;
                        wdata_q   <= rom_data;
                        state_q   <= StWr;
                    end
                end
                StWr: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        bready_q <= 1'b1;
                        state_q  <= StResp;
                    end
                end
                StResp: begin
                    if (cfg_bvalid_i) begin
                        bready_q <= 1'b0;
                        if (cfg_bresp_i != AXI_RESP_OKAY) begin
                            // Abort: the CRTC may be left disabled
                            error_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else if (idx_q == CRTC_LAST_INDEX) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            idx_q     <= idx_q + 4'd1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            awaddr_q  <= BASE_ADDR + rom_offset;
                            wdata_q   <= rom_data;
                            state_q   <= StWr;
                        end
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign cfg_awvalid_o = awvalid_q;
    assign cfg_awaddr_o  = awaddr_q;
    assign cfg_wvalid_o  = wvalid_q;
    assign cfg_wdata_o   = wdata_q;
    assign cfg_wstrb_o   = 4'hF;
    assign cfg_bready_o  = bready_q;

endmodule
